round_judge: RTL and testbench

Judges one Bop-It round: after a `start` pulse it watches the five single-cycle debounced button pulses for the commanded button. It reports HIT, WRONG or TIMEOUT together with the reaction time in clock cycles, and keeps a saturating hit score. It sits directly downstream of the five-button debounce stage and upstream of the game sequencer and display logic.

---
 rtl/round_judge.sv | 114 +++++++++++
 tb/tb_round_judge.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/round_judge.sv
// round_judge: times one Bop-It round, classifies the response as HIT/WRONG/TIMEOUT,
// reports the reaction time and keeps a saturating hit score.
module round_judge #(
    parameter int NUM_BTNS = 5,
    parameter int WIN_W    = 32,
    parameter int SCORE_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          cmd,
    input  logic [WIN_W-1:0]    window,
    input  logic [NUM_BTNS-1:0] btns_d,
    input  logic                clear_score,
    output logic                busy,
    output logic                result_valid,
    output logic [1:0]          result,
    output logic [WIN_W-1:0]    elapsed,
    output logic [SCORE_W-1:0]  score
);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic [1:0] {RES_NONE, RES_HIT, RES_WRONG, RES_TIMEOUT} outcome_t;

    state_t              state;
    state_t              next_state;
    outcome_t            outcome;
    logic                load;
    logic [2:0]          cmd_q;
    logic [WIN_W-1:0]    win_q;
    logic [WIN_W-1:0]    k;
    logic [WIN_W:0]      k_plus;
    logic [NUM_BTNS-1:0] target;

    // One extra bit keeps k+1 from wrapping when compared against the window.
    assign k_plus = {1'b0, k} + (WIN_W+1)'(1);
    assign target = NUM_BTNS'(1) << cmd_q;
    assign busy   = (state == WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        outcome    = RES_NONE;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start && (int'(cmd) < NUM_BTNS)) begin
                    load       = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (btns_d == target) begin
                    outcome = RES_HIT;
                end else if (btns_d != '0) begin
                    outcome = RES_WRONG;
                end else if ((win_q == '0) || (k_plus == {1'b0, win_q})) begin
                    outcome = RES_TIMEOUT;
                end
                if (outcome != RES_NONE) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q <= '0;
            win_q <= '0;
            k     <= '0;
        end else if (load) begin
            cmd_q <= cmd;
            win_q <= window;
            k     <= '0;
        end else if (state == WAIT) begin
            k <= k + WIN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_valid <= 1'b0;
            result       <= 2'b00;
            elapsed      <= '0;
        end else begin
            result_valid <= (outcome != RES_NONE);
            if (outcome != RES_NONE) begin
                result  <= outcome;
                elapsed <= (outcome == RES_TIMEOUT) ? win_q : k;
            end
        end
    end

    // Clear beats a simultaneous HIT; the score sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score <= '0;
        end else if (clear_score) begin
            score <= '0;
        end else if ((outcome == RES_HIT) && (score != {SCORE_W{1'b1}})) begin
            score <= score + SCORE_W'(1);
        end
    end

endmodule

// File: tb/tb_round_judge.sv
// tb_round_judge: table-driven rounds plus hand-written reset, ignore and
// score-saturation sequences for round_judge.
module tb_round_judge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  cmd = '0;
    logic [31:0] window = '0;
    logic [4:0]  btns_d = '0;
    logic        clear_score = 1'b0;
    logic        busy;
    logic        result_valid;
    logic [1:0]  result;
    logic [31:0] elapsed;
    logic [7:0]  score;

    int errors = 0;
    int checks = 0;
    int exp_score = 0;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] window;
        logic [4:0]  start_btns;
        int          press_k;
        logic [4:0]  press_btns;
        int          restart_k;
        logic [1:0]  exp_result;
        logic [31:0] exp_elapsed;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    round_judge #(.NUM_BTNS(5), .WIN_W(32), .SCORE_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .cmd(cmd),
        .window(window),
        .btns_d(btns_d),
        .clear_score(clear_score),
        .busy(busy),
        .result_valid(result_valid),
        .result(result),
        .elapsed(elapsed),
        .score(score)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Runs one round from the table, measuring cycles from busy rising to result_valid.
    task automatic apply_stimulus(input vec_t v);
        int c;
        bit done;
        @(negedge clk);
        start = 1'b1; cmd = v.cmd; window = v.window; btns_d = v.start_btns;
        @(negedge clk);
        start = 1'b0; cmd = '0; window = '0; btns_d = '0;
        check_output("busy_rise", 32'(busy), 32'd1);
        c = 0;
        done = 1'b0;
        while (!done && c < 300) begin
            btns_d = (c == v.press_k) ? v.press_btns : 5'b0;
            if (c == v.restart_k) begin
                start = 1'b1; cmd = 3'd0; window = 32'd5;
            end
            @(negedge clk);
            btns_d = '0; start = 1'b0; cmd = '0; window = '0;
            c++;
            if (result_valid) done = 1'b1;
        end
        if (v.exp_result == 2'b01 && exp_score < 255) exp_score++;
        check_output("round_done", 32'(done), 32'd1);
        check_output("latency", 32'(c), 32'(v.exp_lat));
        check_output("result", 32'(result), 32'(v.exp_result));
        check_output("elapsed", elapsed, v.exp_elapsed);
        check_output("busy_fall", 32'(busy), 32'd0);
        check_output("score", 32'(score), 32'(exp_score));
        @(negedge clk);
        check_output("valid_pulse", 32'(result_valid), 32'd0);
        check_output("result_held", 32'(result), 32'(v.exp_result));
    endtask

    initial begin
        int hits;

        vecs[0]  = '{3'd3, 32'd50, 5'b00000,  7, 5'b01000, -1, 2'b01, 32'd7,  8};
        vecs[1]  = '{3'd1, 32'd50, 5'b00000,  0, 5'b00001, -1, 2'b10, 32'd0,  1};
        vecs[2]  = '{3'd1, 32'd50, 5'b00000,  2, 5'b00011, -1, 2'b10, 32'd2,  3};
        vecs[3]  = '{3'd0, 32'd10, 5'b00000, -1, 5'b00000, -1, 2'b11, 32'd10, 10};
        vecs[4]  = '{3'd0, 32'd10, 5'b00000,  9, 5'b00001, -1, 2'b01, 32'd9,  10};
        vecs[5]  = '{3'd3, 32'd0,  5'b00000, -1, 5'b00000, -1, 2'b11, 32'd0,  1};
        vecs[6]  = '{3'd4, 32'd1,  5'b00000,  0, 5'b10000, -1, 2'b01, 32'd0,  1};
        vecs[7]  = '{3'd2, 32'd1,  5'b00000, -1, 5'b00000, -1, 2'b11, 32'd1,  1};
        vecs[8]  = '{3'd2, 32'd5,  5'b00000,  4, 5'b01000, -1, 2'b10, 32'd4,  5};
        vecs[9]  = '{3'd1, 32'd20, 5'b00010, -1, 5'b00000, -1, 2'b11, 32'd20, 20};
        vecs[10] = '{3'd2, 32'd30, 5'b00000, 12, 5'b00100,  3, 2'b01, 32'd12, 13};

        #3;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_valid", 32'(result_valid), 32'd0);
        check_output("rst_result", 32'(result), 32'd0);
        check_output("rst_elapsed", elapsed, 32'd0);
        check_output("rst_score", 32'(score), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Out-of-range command must not start a round.
        @(negedge clk);
        start = 1'b1; cmd = 3'd5; window = 32'd10;
        @(negedge clk);
        start = 1'b0; cmd = '0;
        check_output("bad_cmd_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check_output("bad_cmd_busy_later", 32'(busy), 32'd0);
        check_output("bad_cmd_valid", 32'(result_valid), 32'd0);

        // Asynchronous reset in the middle of a round at k=40.
        @(negedge clk);
        start = 1'b1; cmd = 3'd2; window = 32'd100;
        @(negedge clk);
        start = 1'b0; cmd = '0; window = '0;
        repeat (40) @(negedge clk);
        check_output("pre_reset_score", 32'(score), 32'(exp_score));
        check_output("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_valid", 32'(result_valid), 32'd0);
        check_output("mid_rst_result", 32'(result), 32'd0);
        check_output("mid_rst_elapsed", elapsed, 32'd0);
        check_output("mid_rst_score", 32'(score), 32'd0);
        exp_score = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            btns_d = 5'b00100;
            @(negedge clk);
            btns_d = '0;
            check_output("post_rst_valid", 32'(result_valid), 32'd0);
        end
        check_output("post_rst_busy", 32'(busy), 32'd0);

        // 257 back-to-back HIT rounds, each start issued alongside result_valid.
        hits = 0;
        @(negedge clk);
        start = 1'b1; cmd = 3'd0; window = 32'd10;
        for (int i = 0; i < 257; i++) begin
            @(negedge clk);
            start = 1'b0;
            btns_d = 5'b00001;
            @(negedge clk);
            btns_d = '0;
            if (result_valid && result == 2'b01 && !busy) hits++;
            if (i < 256) start = 1'b1;
        end
        start = 1'b0; cmd = '0; window = '0;
        check_output("b2b_hits", 32'(hits), 32'd257);
        check_output("score_saturated", 32'(score), 32'd255);

        // Clear wins over a simultaneous HIT.
        @(negedge clk);
        start = 1'b1; cmd = 3'd0; window = 32'd10;
        @(negedge clk);
        start = 1'b0;
        btns_d = 5'b00001;
        clear_score = 1'b1;
        @(negedge clk);
        btns_d = '0;
        clear_score = 1'b0;
        check_output("clear_valid", 32'(result_valid), 32'd1);
        check_output("clear_result", 32'(result), 32'd1);
        check_output("clear_score", 32'(score), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
